// File: rtl/uart_frame_parser.sv
// Frame parser behind a UART receiver: hunts for SOF, captures a length-prefixed
// payload, verifies its XOR checksum and releases good payloads on a valid/ready stream.
module uart_frame_parser #(
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 52080
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  // Expiry fires on the clock where the counter would step onto TIMEOUT_CLKS-1.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 2);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_DROP    = 2'b11;

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    out_data_q;

  logic          wr_en;
  logic          rd_load;
  logic [AW-1:0] rd_addr;
  logic          last_beat;

  logic [7:0] buf_mem [0:(1<<AW)-1];

  assign last_beat = (rd_idx_q == len_q - IW'(1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    chk_d       = chk_q;
    tmo_d       = tmo_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    wr_en       = 1'b0;
    rd_load     = 1'b0;
    rd_addr     = rd_idx_q[AW-1:0];

    case (state_q)
      HUNT: begin
        tmo_d = '0;
        if (rx_done && rx_data == SOF_BYTE) state_d = LEN;
      end

      LEN, PAYLOAD, CHECK: begin
        if (rx_done) begin
          tmo_d = '0;
          if (state_q == LEN) begin
            if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_LEN;
              state_d     = HUNT;
            end else begin
              len_d   = rx_data[IW-1:0];
              chk_d   = rx_data;
              idx_d   = '0;
              state_d = PAYLOAD;
            end
          end else if (state_q == PAYLOAD) begin
            wr_en = 1'b1;
            chk_d = chk_q ^ rx_data;
            idx_d = idx_q + IW'(1);
            if (idx_q == len_q - IW'(1)) state_d = CHECK;
          end else if (rx_data == chk_q) begin
            frame_ok_d = 1'b1;
            rd_idx_d   = '0;
            rd_addr    = '0;
            rd_load    = 1'b1;
            state_d    = DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = HUNT;
          end
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          tmo_d       = '0;
          state_d     = HUNT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      DRAIN: begin
        if (rx_done) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_DROP;
        end
        if (out_ready) begin
          if (last_beat) begin
            state_d = HUNT;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
            rd_addr  = rd_idx_d[AW-1:0];
            rd_load  = 1'b1;
          end
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      len_q       <= '0;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload buffer: write port has no reset; the read register feeds out_data directly.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[idx_q[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst)          out_data_q <= '0;
    else if (rd_load) out_data_q <= buf_mem[rd_addr];
  end

  assign out_data  = out_data_q;
  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid & last_beat;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != HUNT);

endmodule
